// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the external RAM port arbiter.
package sram_arb_pkg;

  localparam int AW_DEF = 23;
  localparam int DW_DEF = 8;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Owner of the access in flight
  typedef enum logic {
    LD  = 1'b0,
    CPU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the requesters (loader, CPU), the arbiter and the
// sram controller. The slave modport is the arbiter's view.
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          dl_active;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_din;
  logic          ld_ack;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          cpu_ack;
  logic [DW-1:0] cpu_dout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic          mem_rd;
  logic [DW-1:0] mem_dout;
  logic          mem_ready;
  logic          timeout_err;

  modport master (
    output dl_active, ld_req, ld_addr, ld_din, cpu_req, cpu_we, cpu_addr,
           cpu_din, mem_dout, mem_ready,
    input  ld_ack, cpu_ack, cpu_dout, mem_addr, mem_din, mem_we, mem_rd,
           timeout_err
  );

  modport slave (
    input  dl_active, ld_req, ld_addr, ld_din, cpu_req, cpu_we, cpu_addr,
           cpu_din, mem_dout, mem_ready,
    output ld_ack, cpu_ack, cpu_dout, mem_addr, mem_din, mem_we, mem_rd,
           timeout_err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant (loader / CPU) with a loader-only override
// while a download is active. Holds the last_grant register.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       prio,
  input  logic       ld_req,
  input  logic       cpu_req,
  input  logic       upd_en,
  input  arb_owner_e upd_owner,
  output logic       gnt_valid,
  output arb_owner_e gnt_owner
);

  arb_owner_e last_grant_r;

  // Remember who completed last; starts at LD so the CPU wins the first tie
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      last_grant_r <= LD;
    end else if (upd_en) begin
      last_grant_r <= upd_owner;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Grant decision: download override first, then single request, then alternate
  always_comb begin
    gnt_valid = 1'b0;
    gnt_owner = LD;
    if (prio) begin
      gnt_valid = ld_req;
      gnt_owner = LD;
    end else if (ld_req && cpu_req) begin
      gnt_valid = 1'b1;
      if (last_grant_r == LD) begin
        gnt_owner = CPU;
      end else begin
        gnt_owner = LD;
      end
    end else if (cpu_req) begin
      gnt_valid = 1'b1;
      gnt_owner = CPU;
    end else if (ld_req) begin
      gnt_valid = 1'b1;
      gnt_owner = LD;
    end else begin
      gnt_valid = 1'b0;
      gnt_owner = LD;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Sequenced arbiter sharing the byte-wide sram controller port between the
// ioctl loader and the CPU. One access at a time: grant, issue, wait for
// mem_ready (bounded by TIMEOUT), then a one-cycle ack to the owner.
// Optional write protection of the CPU ROM area: define SRAM_ARB_WP_EN.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 255
`ifdef SRAM_ARB_WP_EN
  ,
  parameter logic [AW-1:0] ROM_TOP = 23'h010000
`endif
) (
  input logic                 clk_sys,
  input logic                 reset,
  sram_port_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_DONE  = DONE;

  // Last WAIT cycle index before the access is abandoned
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]    state_r;
  arb_owner_e    owner_r;
  logic          we_r;
  logic [7:0]    cnt_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_din_r;
  logic          mem_we_r;
  logic          mem_rd_r;
  logic          ld_ack_r;
  logic          cpu_ack_r;
  logic [DW-1:0] cpu_dout_r;
  logic          timeout_err_r;

  logic          gnt_valid_s;
  arb_owner_e    gnt_owner_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_din_s;
  logic          sel_we_s;
  logic          wp_hit_s;
  logic          upd_en_s;

  assign upd_en_s = (state_r == ST_DONE);

  rr_arb2 u_rr_arb2 (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .prio      (bus.dl_active),
    .ld_req    (bus.ld_req),
    .cpu_req   (bus.cpu_req),
    .upd_en    (upd_en_s),
    .upd_owner (owner_r),
    .gnt_valid (gnt_valid_s),
    .gnt_owner (gnt_owner_s)
  );

  // Route the granted requester's fields to the latch inputs
  always_comb begin
    sel_addr_s = bus.ld_addr;
    sel_din_s  = bus.ld_din;
    sel_we_s   = 1'b1;
    if (gnt_owner_s == CPU) begin
      sel_addr_s = bus.cpu_addr;
      sel_din_s  = bus.cpu_din;
      sel_we_s   = bus.cpu_we;
    end else begin
      sel_addr_s = bus.ld_addr;
      sel_din_s  = bus.ld_din;
      sel_we_s   = 1'b1;
    end
  end

`ifdef SRAM_ARB_WP_EN
  // CPU writes below ROM_TOP are acknowledged but never reach memory
  assign wp_hit_s = (gnt_owner_s == CPU) && bus.cpu_we && (bus.cpu_addr < ROM_TOP);
`else
  assign wp_hit_s = 1'b0;
`endif

  // Access sequencer: latch at grant, strobe until ready or timeout, ack once
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      owner_r       <= LD;
      we_r          <= 1'b0;
      cnt_r         <= 8'd0;
      mem_addr_r    <= {AW{1'b0}};
      mem_din_r     <= {DW{1'b0}};
      mem_we_r      <= 1'b0;
      mem_rd_r      <= 1'b0;
      ld_ack_r      <= 1'b0;
      cpu_ack_r     <= 1'b0;
      cpu_dout_r    <= {DW{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      ld_ack_r  <= 1'b0;
      cpu_ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (gnt_valid_s) begin
            owner_r <= gnt_owner_s;
            we_r    <= sel_we_s;
            if (wp_hit_s) begin
              cpu_ack_r <= 1'b1;
              state_r   <= ST_DONE;
            end else begin
              mem_addr_r <= sel_addr_s;
              mem_din_r  <= sel_din_s;
              mem_we_r   <= sel_we_s;
              mem_rd_r   <= ~sel_we_s;
              state_r    <= ST_ISSUE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          cnt_r   <= 8'd0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.mem_ready || (cnt_r == TMO_LAST)) begin
            mem_we_r <= 1'b0;
            mem_rd_r <= 1'b0;
            state_r  <= ST_DONE;
            if (owner_r == CPU) begin
              cpu_ack_r <= 1'b1;
            end else begin
              ld_ack_r <= 1'b1;
            end
            if (bus.mem_ready) begin
              if ((owner_r == CPU) && !we_r) begin
                cpu_dout_r <= bus.mem_dout;
              end else begin
                cpu_dout_r <= cpu_dout_r;
              end
            end else begin
              timeout_err_r <= 1'b1;
              if ((owner_r == CPU) && !we_r) begin
                cpu_dout_r <= {DW{1'b1}};
              end else begin
                cpu_dout_r <= cpu_dout_r;
              end
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_we_r <= 1'b0;
          mem_rd_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ld_ack      = ld_ack_r;
  assign bus.cpu_ack     = cpu_ack_r;
  assign bus.cpu_dout    = cpu_dout_r;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_din     = mem_din_r;
  assign bus.mem_we      = mem_we_r;
  assign bus.mem_rd      = mem_rd_r;
  assign bus.timeout_err = timeout_err_r;

endmodule
